// File: rtl/regfile_sb_if.sv
// Bundle of read, write and issue ports for the scoreboarded register file.
interface regfile_sb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NISSUE = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NISSUE*2*AW-1:0]   rd_addr;
  logic [NISSUE*2*XLEN-1:0] rd_data;
  logic [NISSUE*2-1:0]      rd_busy;
  logic [NISSUE-1:0]        wr_en;
  logic [NISSUE*AW-1:0]     wr_addr;
  logic [NISSUE*XLEN-1:0]   wr_data;
  logic [NISSUE-1:0]        iss_en;
  logic [NISSUE*AW-1:0]     iss_addr;
  logic [AW:0]              busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-issue register file with per-register pending (busy) scoreboard.
// Optional same-cycle write-to-read forwarding enabled by macro REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NISSUE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int unsigned AW  = $clog2(NREG);
  localparam int unsigned NRD = 2 * NISSUE;

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;

  logic [NREG-1:0] w_wr_hit;
  logic [NREG-1:0] w_iss_hit;
  logic [XLEN-1:0] w_wr_val [NREG];
  logic [NREG-1:0] w_busy_d;
  logic [AW:0]     w_busy_cnt_d;
  logic [AW-1:0]   w_rd_addr [NRD];

  // Per-register write/issue decode; ascending slot scan lets the highest slot win.
  always_comb begin
    w_wr_hit  = '0;
    w_iss_hit = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      w_wr_val[r] = '0;
      for (int unsigned s = 0; s < NISSUE; s++) begin
        if (bus.wr_en[s] && (bus.wr_addr[s*AW +: AW] == AW'(r))) begin
          w_wr_hit[r] = 1'b1;
          w_wr_val[r] = bus.wr_data[s*XLEN +: XLEN];
        end
        if (bus.iss_en[s] && (bus.iss_addr[s*AW +: AW] == AW'(r))) begin
          w_iss_hit[r] = 1'b1;
        end
      end
    end
    w_wr_hit[0]  = 1'b0;
    w_iss_hit[0] = 1'b0;
  end

  always_comb begin
    w_busy_d     = w_iss_hit | (r_busy & ~w_wr_hit);
    w_busy_cnt_d = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      w_busy_cnt_d = w_busy_cnt_d + (AW+1)'(w_busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_val[r];
        end
      end
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_busy_cnt_d;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      w_rd_addr[p] = bus.rd_addr[p*AW +: AW];
    end
  end

  // Outputs are forced low while reset is held so forwarded data cannot leak out.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
`ifdef REGFILE_SB_BYPASS_EN
      if (w_wr_hit[w_rd_addr[p]]) begin
        bus.rd_data[p*XLEN +: XLEN] = w_wr_val[w_rd_addr[p]];
        bus.rd_busy[p]              = w_iss_hit[w_rd_addr[p]];
      end else begin
        bus.rd_data[p*XLEN +: XLEN] = r_regs[w_rd_addr[p]];
        bus.rd_busy[p]              = r_busy[w_rd_addr[p]];
      end
`else
      bus.rd_data[p*XLEN +: XLEN] = r_regs[w_rd_addr[p]];
      bus.rd_busy[p]              = r_busy[w_rd_addr[p]];
`endif
      if (!rst_n) begin
        bus.rd_data[p*XLEN +: XLEN] = '0;
        bus.rd_busy[p]              = 1'b0;
      end
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

endmodule
